key_schedule_ctrl: RTL and testbench

- Sequential controller that drives the combinational single-round AES-128 key-expansion step (128-bit key in, 32-bit Rcon word in, 128-bit next round key out).
- Given a cipher key, it steps that datapath 10 times, generating Rcon on the fly.
- Streams round keys 0..10 to the encryption core over a valid/ready handshake.
- Sits between the key-load interface and the AddRoundKey stage of the encryption pipeline.

---
 rtl/key_schedule_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule controller: steps a single-round expansion datapath and streams round keys 0..10.
// Optional macro KS_STORE_EN adds an 11-entry round-key file with a combinational read port.
package ks_pkg;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

module ks_expand_step (
    input  logic [127:0] key,
    input  logic [31:0]  rcon_word,
    output logic [127:0] next_key
);
    import ks_pkg::*;

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] temp_s, n0_s, n1_s, n2_s, n3_s;

    assign w0_s   = key[127:96];
    assign w1_s   = key[95:64];
    assign w2_s   = key[63:32];
    assign w3_s   = key[31:0];
    assign temp_s = sub_word({w3_s[23:0], w3_s[31:24]}) ^ rcon_word;
    assign n0_s   = w0_s ^ temp_s;
    assign n1_s   = w1_s ^ n0_s;
    assign n2_s   = w2_s ^ n1_s;
    assign n3_s   = w3_s ^ n2_s;
    assign next_key = {n0_s, n1_s, n2_s, n3_s};

endmodule

module key_schedule_ctrl #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_idx,
`ifdef KS_STORE_EN
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key,
`endif
    output logic         done
);
    import ks_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01
    } state_t;

    state_t       state_r;
    logic [7:0]   rcon_r;
    logic [127:0] next_key_s;
    logic         xfer_s;

    ks_expand_step u_step (
        .key       (round_key),
        .rcon_word ({rcon_r, 24'h000000}),
        .next_key  (next_key_s)
    );

    assign xfer_s = rk_valid & rk_ready;
    // done is tied to the accepting cycle itself, so it cannot be delayed by a register.
    assign done   = xfer_s & (rk_idx == LAST_IDX);

    // Control FSM; round_key doubles as the key register feeding the expansion step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            round_key <= 128'h0;
            rk_idx    <= 4'd0;
            rcon_r    <= RCON_INIT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        rk_idx    <= 4'd0;
                        rcon_r    <= RCON_INIT;
                        busy      <= 1'b1;
                        rk_valid  <= 1'b1;
                        state_r   <= EMIT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rk_idx == LAST_IDX) begin
                            busy     <= 1'b0;
                            rk_valid <= 1'b0;
                            state_r  <= IDLE;
                        end else begin
                            round_key <= next_key_s;
                            rk_idx    <= rk_idx + 4'd1;
                            rcon_r    <= xtime(rcon_r);
                            state_r   <= EMIT;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    busy     <= 1'b0;
                    rk_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

`ifdef KS_STORE_EN
    logic [127:0] store_r [0:10];

    // Round-key file, written with each accepted key and kept until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                store_r[i] <= 128'h0;
            end
        end else begin
            if (xfer_s && (rk_idx <= LAST_IDX)) begin
                store_r[rk_idx] <= round_key;
            end else begin
                store_r <= store_r;
            end
        end
    end

    assign rd_key = (rd_addr <= LAST_IDX) ? store_r[rd_addr] : 128'h0;
`endif

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: FIPS-197 word-based key-expansion model plus directed runs.
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         busy, rk_valid, done;
    logic         rk_ready = 1'b1;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
`ifdef KS_STORE_EN
    logic [3:0]   rd_addr = 4'd0;
    logic [127:0] rd_key;
`endif

    key_schedule_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_idx    (rk_idx),
`ifdef KS_STORE_EN
        .rd_addr   (rd_addr),
        .rd_key    (rd_key),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090A0B0C0D0E0F;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    logic [7:0]   alog [0:255];
    int           lg   [0:255];
    logic [127:0] seen [0:10];
    logic [7:0]   seen_rcon [0:10];

    // Transaction-level model state.
    logic         m_busy = 1'b0;
    int           m_idx = 0;
    logic [127:0] m_key = 128'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            alog[i] = e[7:0];
            lg[e]   = i;
            e = e ^ (e << 1);
            if (e > 255) e = e ^ 'h11B;
        end
        alog[255] = 8'h01;
        lg[0] = 0;
    endtask

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] b, s, c;
        b = (x == 8'h00) ? 8'h00 : alog[(255 - lg[x]) % 255];
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [7:0] model_rcon(input int r);
        int v;
        v = 1;
        for (int j = 1; j < r; j++) begin
            v = v * 2;
            if (v > 255) v = v ^ 'h11B;
        end
        return v[7:0];
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] k, input int n);
        logic [31:0] w [0:43];
        logic [31:0] t;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])}
                    ^ {model_rcon(i / 4), 24'h000000};
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Model: a key sequence is in flight from an accepted start until key 10 is taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_idx  <= 0;
                m_key  <= key_in;
            end
        end else if (rk_ready) begin
            if (m_idx == 10) m_busy <= 1'b0;
            else             m_idx  <= m_idx + 1;
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("rk_valid", rk_valid, m_busy);
        chk("done", done, m_busy && rk_ready && (m_idx == 10));
        if (m_busy) begin
            chk("rk_idx", rk_idx, m_idx);
            chk("round_key", round_key, model_rk(m_key, m_idx));
            if (m_idx < 10) chk("rcon", dut.rcon_r, model_rcon(m_idx + 1));
        end
        if (rk_valid) begin
            seen[rk_idx]      <= round_key;
            seen_rcon[rk_idx] <= dut.rcon_r;
        end
        if (done) done_seen <= done_seen + 1;
    end

    task automatic pulse_start(input logic [127:0] k);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int n;
        n = 0;
        while (rk_idx != target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idx", rk_idx, target);
    endtask

    initial begin
        logic [7:0] rc_list [0:9];
        int d_before;
        build_tables();
        rc_list = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

        // Pin the model against published values.
        chk("model_k1", model_rk(FIPS_KEY, 1), 128'hA0FAFE1788542CB123A339392A6C7605);
        chk("model_k2", model_rk(FIPS_KEY, 2), 128'hF2C295F27A96B9435935807A7359F67F);
        chk("model_k10", model_rk(FIPS_KEY, 10), 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        chk("model_seq1", model_rk(SEQ_KEY, 1), 128'hD6AA74FDD2AF72FADAA678F1D6AB76FE);
        for (int r = 1; r <= 10; r++) chk("model_rcon", model_rcon(r), rc_list[r-1]);

        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rk_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_key", round_key, 128'h0);
        chk("rst_idx", rk_idx, 4'd0);
        chk("rst_rcon", dut.rcon_r, 8'h01);
        @(negedge clk) rst_n = 1'b1;

        // Full throughput run.
        rk_ready = 1'b1;
        pulse_start(FIPS_KEY);
        wait_done("run1_timeout");
        chk("run1_k0", seen[0], FIPS_KEY);
        chk("run1_k1", seen[1], 128'hA0FAFE1788542CB123A339392A6C7605);
        chk("run1_k2", seen[2], 128'hF2C295F27A96B9435935807A7359F67F);
        chk("run1_k10", seen[10], 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        chk("run1_done", done_seen, 1);
        for (int r = 1; r <= 10; r++) chk("run1_rcon", seen_rcon[r-1], rc_list[r-1]);

        // Backpressure run: rk_ready 1,0,0 repeating.
        pulse_start(FIPS_KEY);
        for (int i = 1; busy && i < 200; i++) begin
            @(posedge clk); #1;
            rk_ready = (i % 3 == 0);
        end
        rk_ready = 1'b1;
        chk("run2_idle", busy, 1'b0);
        chk("run2_k1", seen[1], 128'hA0FAFE1788542CB123A339392A6C7605);
        chk("run2_k10", seen[10], 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        chk("run2_done", done_seen, 2);

        // start while busy, and start during the final transfer, are both ignored.
        pulse_start(FIPS_KEY);
        wait_idx(4'd4);
        start = 1'b1; key_in = SEQ_KEY;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idx(4'd10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("run3_idle", busy, 1'b0);
        chk("run3_k10", seen[10], 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        chk("run3_done", done_seen, 3);

        // Asynchronous reset mid-sequence.
        pulse_start(FIPS_KEY);
        wait_idx(4'd6);
        d_before = done_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", rk_valid, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        chk("arst_nodone", done_seen, d_before);
        rst_n = 1'b1;
        pulse_start(SEQ_KEY);
        wait_done("run4_timeout");
        chk("run4_k0", seen[0], SEQ_KEY);
        chk("run4_k1", seen[1], 128'hD6AA74FDD2AF72FADAA678F1D6AB76FE);
        chk("run4_done", done_seen, d_before + 1);

`ifdef KS_STORE_EN
        pulse_start(FIPS_KEY);
        wait_done("run5_timeout");
        rd_addr = 4'd10; #1;
        chk("rd_10", rd_key, 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        rd_addr = 4'd1; #1;
        chk("rd_1", rd_key, 128'hA0FAFE1788542CB123A339392A6C7605);
        rd_addr = 4'd15; #1;
        chk("rd_15", rd_key, 128'h0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
